axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Upstream neighbour of the AXI SRAM slave interface.
- Merges the AR channels of `masters` independent AXI masters onto the single slave AR port, using round-robin arbitration.
- Tags each granted request with a one-hot ARMASTER.
- Returns R beats to the owning master by decoding RMASTER.
- Enforces a per-master limit on outstanding read bursts and flags R-channel routing errors.

Parameters:
- masters, 4, number of upstream masters; also the width of ARMASTER/RMASTER.
- width, 22, address width.
- id_bits, 2, transaction ID width.
- b_size, 3, bus width is 2^b_size bytes (64-bit data at default).
- max_outst, 4, maximum outstanding read bursts per master (1..15).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous, active-low reset.
- M_ARID  in  masters*id_bits  per-master ARID, master i at slice i.
- M_ARADDR  in  masters*width  per-master ARADDR.
- M_ARLEN  in  masters*4  per-master ARLEN.
- M_ARSIZE  in  masters*3  per-master ARSIZE.
- M_ARBURST  in  masters*2  per-master ARBURST.
- M_ARVALID  in  masters  per-master ARVALID.
- M_ARREADY  out  masters  per-master ARREADY.
- M_RID  out  id_bits  broadcast RID.
- M_RDATA  out  8*2^b_size  broadcast RDATA.
- M_RRESP  out  2  broadcast RRESP.
- M_RLAST  out  1  broadcast RLAST.
- M_RVALID  out  masters  per-master RVALID.
- M_RREADY  in  masters  per-master RREADY.
- ARMASTER  out  masters  one-hot owner of the current request.
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST  out  id_bits/width/4/3/2  registered request.
- ARLOCK, ARCACHE, ARPROT  out  2/4/3  tied to 0.
- ARVALID  out  1  request valid.
- ARREADY  in  1  slave accept.
- RMASTER  in  masters  one-hot owner of the R beat.
- RID, RDATA, RRESP, RLAST  in  widths as above.
- RVALID  in  1  slave R valid.
- RREADY  out  1  to slave.
- ROUTE_ERR  out  1  sticky R routing error.

Behaviour:
- Reset (ARESETn=0 at a rising ACLK edge):
  - state=IDLE, ARVALID=0, ARMASTER=0, all AR payload registers=0.
  - rr_ptr=masters-1, so master 0 has first priority.
  - All outst[i]=0, ROUTE_ERR=0, M_ARREADY=0.
- Eligibility: eligible[i] = M_ARVALID[i] && (outst[i] != max_outst).
- FSM IDLE:
  - winner = first eligible index searching rr_ptr+1, rr_ptr+2, … modulo masters.
  - M_ARREADY[winner]=1 combinationally; all other M_ARREADY bits are 0.
  - If any master is eligible: capture the winner's payload into the AR registers, set ARMASTER=1<<winner, set rr_ptr=winner, ARVALID<=1, go to HOLD.
  - No eligible master: stay in IDLE, all M_ARREADY=0.
- FSM HOLD:
  - All M_ARREADY=0; AR outputs are held stable.
  - On ARVALID&&ARREADY: ARVALID<=0, go to IDLE.
- Latency and throughput:
  - One cycle from master handshake to ARVALID.
  - Maximum throughput is one request per 2 cycles.
  - The request is visible on AR outputs no earlier than the cycle after capture.
- Outstanding counters, outst[i] 4 bits:
  - Increment on capture for master i.
  - Decrement on an R handshake (RVALID&&RREADY) with RLAST and RMASTER[i].
  - Both events in the same cycle: net unchanged.
  - Decrement at 0: counter stays 0 and ROUTE_ERR<=1.
- R routing, combinational:
  - M_RVALID[i] = RVALID && RMASTER[i].
  - RREADY = |(RMASTER & M_RREADY).
  - RID/RDATA/RRESP/RLAST are broadcast unmodified.
- ROUTE_ERR:
  - Set when RVALID=1 and RMASTER is zero or not one-hot.
  - Cleared only by reset.
  - While RMASTER is bad, RREADY=0 and all M_RVALID=0, so the beat stalls.
- Reset mid-operation: a pending HOLD request is dropped. Masters must not assume completion.
- Stability: AR payload is fixed while ARVALID=1 && !ARREADY. RVALID is never gated by RREADY.

Test Plan:
- Single request: master 2 asserts ARVALID with ARADDR=0x000100, ARLEN=3, ARID=1 → M_ARREADY[2]=1 for one cycle. Next cycle ARVALID=1, ARMASTER=4'b0100, ARADDR=0x000100. With ARREADY=1, ARVALID drops the following cycle.
- Round-robin: all 4 masters hold ARVALID continuously, ARREADY=1 → grant order 0,1,2,3,0,1. Each grant is 2 cycles apart.
- Outstanding limit (max_outst=2): master 0 issues 2 bursts with no R traffic, and a third request is pending → no third grant; master 1 is served instead. After one R beat with RLAST=1, RMASTER=4'b0001 is accepted, master 0 is granted next.
- R routing: RVALID=1, RMASTER=4'b1000, RDATA=0xDEADBEEF_01234567, M_RREADY=4'b0111 → M_RVALID=4'b1000, RREADY=0. Setting M_RREADY[3]=1 → RREADY=1.
- Error: RVALID=1 with RMASTER=4'b0110 → ROUTE_ERR=1 the next cycle, RREADY=0, M_RVALID=0. ROUTE_ERR stays 1 until ARESETn=0.
- Reset in HOLD: hold ARREADY=0 after a grant, then pulse ARESETn=0 → ARVALID=0, outst all 0. After reset, master 0 wins first.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin merge of several AXI read-address channels onto one slave AR port,
// with one-hot owner tagging, R-beat return routing and per-master outstanding limits.
module axi_read_arbiter #(
    parameter int masters   = 4,
    parameter int width     = 22,
    parameter int id_bits   = 2,
    parameter int b_size    = 3,
    parameter int max_outst = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [masters*id_bits-1:0]    M_ARID,
    input  logic [masters*width-1:0]      M_ARADDR,
    input  logic [masters*4-1:0]          M_ARLEN,
    input  logic [masters*3-1:0]          M_ARSIZE,
    input  logic [masters*2-1:0]          M_ARBURST,
    input  logic [masters-1:0]            M_ARVALID,
    output logic [masters-1:0]            M_ARREADY,
    output logic [id_bits-1:0]            M_RID,
    output logic [8*(2**b_size)-1:0]      M_RDATA,
    output logic [1:0]                    M_RRESP,
    output logic                          M_RLAST,
    output logic [masters-1:0]            M_RVALID,
    input  logic [masters-1:0]            M_RREADY,
    output logic [masters-1:0]            ARMASTER,
    output logic [id_bits-1:0]            ARID,
    output logic [width-1:0]              ARADDR,
    output logic [3:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    output logic [1:0]                    ARLOCK,
    output logic [3:0]                    ARCACHE,
    output logic [2:0]                    ARPROT,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [masters-1:0]            RMASTER,
    input  logic [id_bits-1:0]            RID,
    input  logic [8*(2**b_size)-1:0]      RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic                          ROUTE_ERR
);

    localparam int idx_w = (masters > 1) ? $clog2(masters) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic is_onehot(input logic [masters-1:0] v);
        return (v != '0) && ((v & (v - masters'(1))) == '0);
    endfunction

    state_t                 state_r, state_nx_s;
    logic [idx_w-1:0]       rr_ptr_r;
    logic [3:0]             outst_r [masters];
    logic [masters-1:0]     elig_s;
    logic [masters-1:0]     inc_s, dec_s;
    logic [idx_w-1:0]       winner_s;
    logic                   any_elig_s;
    logic                   capture_s;
    logic                   rmaster_ok_s;
    logic                   r_hs_s;
    logic                   err_set_s;

    logic [masters-1:0]     ar_master_r;
    logic [id_bits-1:0]     ar_id_r;
    logic [width-1:0]       ar_addr_r;
    logic [3:0]             ar_len_r;
    logic [2:0]             ar_size_r;
    logic [1:0]             ar_burst_r;
    logic                   ar_valid_r;
    logic                   route_err_r;

    // Eligibility: a master with its outstanding budget exhausted is skipped.
    always_comb begin
        for (int i = 0; i < masters; i++) begin
            elig_s[i] = M_ARVALID[i] && (outst_r[i] != 4'(max_outst));
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        idx        = 0;
        winner_s   = '0;
        any_elig_s = 1'b0;
        for (int k = 1; k <= masters; k++) begin
            idx = (int'(rr_ptr_r) + k) % masters;
            if (!any_elig_s && elig_s[idx]) begin
                any_elig_s = 1'b1;
                winner_s   = idx_w'(idx);
            end else begin
                any_elig_s = any_elig_s;
            end
        end
    end

    assign capture_s = (state_r == IDLE) && any_elig_s && ARESETn;

    // Grant strobe back to the winning master, only while a capture happens.
    always_comb begin
        M_ARREADY = '0;
        if (capture_s) begin
            M_ARREADY[winner_s] = 1'b1;
        end else begin
            M_ARREADY = '0;
        end
    end

    // Next-state logic of the request FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_elig_s) begin
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HOLD: begin
                if (ar_valid_r && ARREADY) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus the registered AR request.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r     <= IDLE;
            rr_ptr_r    <= idx_w'(masters - 1);
            ar_master_r <= '0;
            ar_id_r     <= '0;
            ar_addr_r   <= '0;
            ar_len_r    <= 4'd0;
            ar_size_r   <= 3'd0;
            ar_burst_r  <= 2'd0;
            ar_valid_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (capture_s) begin
                rr_ptr_r    <= winner_s;
                ar_master_r <= masters'(1) << winner_s;
                ar_id_r     <= M_ARID[int'(winner_s)*id_bits +: id_bits];
                ar_addr_r   <= M_ARADDR[int'(winner_s)*width +: width];
                ar_len_r    <= M_ARLEN[int'(winner_s)*4 +: 4];
                ar_size_r   <= M_ARSIZE[int'(winner_s)*3 +: 3];
                ar_burst_r  <= M_ARBURST[int'(winner_s)*2 +: 2];
                ar_valid_r  <= 1'b1;
            end else if (ar_valid_r && ARREADY) begin
                ar_valid_r  <= 1'b0;
            end
        end
    end

    // R routing: a beat with a malformed owner is neither forwarded nor accepted.
    assign rmaster_ok_s = is_onehot(RMASTER);
    assign M_RVALID     = (RVALID && rmaster_ok_s) ? RMASTER : '0;
    assign RREADY       = rmaster_ok_s && (|(RMASTER & M_RREADY));
    assign r_hs_s       = RVALID && RREADY;
    assign M_RID        = RID;
    assign M_RDATA      = RDATA;
    assign M_RRESP      = RRESP;
    assign M_RLAST      = RLAST;

    // Per-master burst open/close events.
    always_comb begin
        for (int i = 0; i < masters; i++) begin
            inc_s[i] = capture_s && (winner_s == idx_w'(i));
            dec_s[i] = r_hs_s && RLAST && RMASTER[i];
        end
    end

    // Error when a beat's owner is malformed or closes a burst it never opened.
    always_comb begin
        err_set_s = RVALID && !rmaster_ok_s;
        for (int i = 0; i < masters; i++) begin
            if (dec_s[i] && !inc_s[i] && (outst_r[i] == 4'd0)) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = err_set_s;
            end
        end
    end

    // Outstanding-burst counters; an unmatched close at zero saturates.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < masters; i++) begin
                outst_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < masters; i++) begin
                if (inc_s[i] && !dec_s[i]) begin
                    outst_r[i] <= outst_r[i] + 4'd1;
                end else if (dec_s[i] && !inc_s[i] && (outst_r[i] != 4'd0)) begin
                    outst_r[i] <= outst_r[i] - 4'd1;
                end
            end
        end
    end

    // Sticky routing error, cleared only by reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            route_err_r <= 1'b0;
        end else if (err_set_s) begin
            route_err_r <= 1'b1;
        end
    end

    assign ARMASTER  = ar_master_r;
    assign ARID      = ar_id_r;
    assign ARADDR    = ar_addr_r;
    assign ARLEN     = ar_len_r;
    assign ARSIZE    = ar_size_r;
    assign ARBURST   = ar_burst_r;
    assign ARLOCK    = 2'b00;
    assign ARCACHE   = 4'b0000;
    assign ARPROT    = 3'b000;
    assign ARVALID   = ar_valid_r;
    assign ROUTE_ERR = route_err_r;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with four masters and an outstanding limit of two.
module tb_axi_read_arbiter;

    localparam int masters = 4;
    localparam int width   = 22;
    localparam int id_bits = 2;
    localparam int b_size  = 3;
    localparam int dw      = 8 * (2 ** b_size);

    logic                       ACLK = 1'b0;
    logic                       ARESETn;
    logic [masters*id_bits-1:0] M_ARID;
    logic [masters*width-1:0]   M_ARADDR;
    logic [masters*4-1:0]       M_ARLEN;
    logic [masters*3-1:0]       M_ARSIZE;
    logic [masters*2-1:0]       M_ARBURST;
    logic [masters-1:0]         M_ARVALID;
    logic [masters-1:0]         M_ARREADY;
    logic [id_bits-1:0]         M_RID;
    logic [dw-1:0]              M_RDATA;
    logic [1:0]                 M_RRESP;
    logic                       M_RLAST;
    logic [masters-1:0]         M_RVALID;
    logic [masters-1:0]         M_RREADY;
    logic [masters-1:0]         ARMASTER;
    logic [id_bits-1:0]         ARID;
    logic [width-1:0]           ARADDR;
    logic [3:0]                 ARLEN;
    logic [2:0]                 ARSIZE;
    logic [1:0]                 ARBURST;
    logic [1:0]                 ARLOCK;
    logic [3:0]                 ARCACHE;
    logic [2:0]                 ARPROT;
    logic                       ARVALID;
    logic                       ARREADY;
    logic [masters-1:0]         RMASTER;
    logic [id_bits-1:0]         RID;
    logic [dw-1:0]              RDATA;
    logic [1:0]                 RRESP;
    logic                       RLAST;
    logic                       RVALID;
    logic                       RREADY;
    logic                       ROUTE_ERR;

    int total = 0;
    int bad   = 0;

    axi_read_arbiter #(
        .masters(masters), .width(width), .id_bits(id_bits),
        .b_size(b_size), .max_outst(2)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
        .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID),
        .M_ARREADY(M_ARREADY), .M_RID(M_RID), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY), .ARMASTER(ARMASTER), .ARID(ARID),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RMASTER(RMASTER),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .ROUTE_ERR(ROUTE_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        M_ARID = '0; M_ARADDR = '0; M_ARLEN = '0; M_ARSIZE = '0;
        M_ARBURST = '0; M_ARVALID = '0; M_RREADY = '0;
        ARREADY = 1'b0; RMASTER = '0; RID = '0; RDATA = '0;
        RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        #1;
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        do_reset();
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_armaster", 64'(ARMASTER), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);
        chk("rst_m_arready", 64'(M_ARREADY), 64'd0);
        chk("rst_route_err", 64'(ROUTE_ERR), 64'd0);
        chk("rst_artie", 64'({ARLOCK, ARCACHE, ARPROT}), 64'd0);

        // single request from master 2
        M_ARVALID = 4'b0100;
        M_ARADDR[2*width +: width] = 22'h000100;
        M_ARLEN[2*4 +: 4] = 4'd3;
        M_ARID[2*id_bits +: id_bits] = 2'd1;
        ARREADY = 1'b1;
        #1;
        chk("single_grant", 64'(M_ARREADY), 64'h4);
        tick();
        M_ARVALID = 4'b0000;
        #1;
        chk("single_arvalid", 64'(ARVALID), 64'd1);
        chk("single_armaster", 64'(ARMASTER), 64'h4);
        chk("single_araddr", 64'(ARADDR), 64'h100);
        chk("single_arlen", 64'(ARLEN), 64'd3);
        chk("single_arid", 64'(ARID), 64'd1);
        chk("single_hold_rdy", 64'(M_ARREADY), 64'd0);
        tick();
        chk("single_drop", 64'(ARVALID), 64'd0);

        // round robin with all masters requesting
        do_reset();
        M_ARVALID = 4'b1111;
        ARREADY = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_grant", 64'(M_ARREADY), 64'(4'b0001 << exp_order[k]));
            tick();
            chk("rr_armaster", 64'(ARMASTER), 64'(4'b0001 << exp_order[k]));
            chk("rr_gap", 64'(M_ARREADY), 64'd0);
            tick();
        end
        chk("rr_skip_full", 64'(M_ARREADY), 64'h4);

        // outstanding limit on master 0
        do_reset();
        M_ARVALID = 4'b0001;
        ARREADY = 1'b1;
        #1;
        chk("lim_g1", 64'(M_ARREADY), 64'h1);
        tick();
        tick();
        chk("lim_g2", 64'(M_ARREADY), 64'h1);
        tick();
        tick();
        M_ARVALID = 4'b0011;
        #1;
        chk("lim_m1_served", 64'(M_ARREADY), 64'h2);
        tick();
        M_ARVALID = 4'b0001;
        tick();
        chk("lim_blocked", 64'(M_ARREADY), 64'd0);
        RVALID = 1'b1; RMASTER = 4'b0001; RLAST = 1'b1; M_RREADY = 4'b0001;
        #1;
        chk("lim_rready", 64'(RREADY), 64'd1);
        chk("lim_m_rvalid", 64'(M_RVALID), 64'h1);
        tick();
        RVALID = 1'b0; RLAST = 1'b0;
        #1;
        chk("lim_regrant", 64'(M_ARREADY), 64'h1);
        chk("lim_no_err", 64'(ROUTE_ERR), 64'd0);

        // R routing
        do_reset();
        RVALID = 1'b1; RMASTER = 4'b1000; RDATA = 64'hDEADBEEF_01234567;
        M_RREADY = 4'b0111;
        #1;
        chk("rt_m_rvalid", 64'(M_RVALID), 64'h8);
        chk("rt_rready0", 64'(RREADY), 64'd0);
        chk("rt_rdata", 64'(M_RDATA), 64'hDEADBEEF_01234567);
        M_RREADY = 4'b1111;
        #1;
        chk("rt_rready1", 64'(RREADY), 64'd1);
        tick();
        chk("rt_no_err", 64'(ROUTE_ERR), 64'd0);

        // malformed RMASTER
        RMASTER = 4'b0110;
        #1;
        chk("err_rready", 64'(RREADY), 64'd0);
        chk("err_m_rvalid", 64'(M_RVALID), 64'd0);
        tick();
        chk("err_set", 64'(ROUTE_ERR), 64'd1);
        RVALID = 1'b0; RMASTER = 4'b0000;
        tick();
        tick();
        chk("err_sticky", 64'(ROUTE_ERR), 64'd1);
        do_reset();
        chk("err_cleared", 64'(ROUTE_ERR), 64'd0);

        // unmatched RLAST underflow
        RVALID = 1'b1; RMASTER = 4'b0001; RLAST = 1'b1; M_RREADY = 4'b0001;
        tick();
        chk("uflow_err", 64'(ROUTE_ERR), 64'd1);

        // reset while a request is held
        do_reset();
        M_ARVALID = 4'b0100;
        M_ARADDR[2*width +: width] = 22'h0ABCDE;
        ARREADY = 1'b0;
        tick();
        M_ARVALID = 4'b0000;
        tick();
        tick();
        chk("hold_valid", 64'(ARVALID), 64'd1);
        chk("hold_addr", 64'(ARADDR), 64'h0ABCDE);
        ARESETn = 1'b0;
        tick();
        chk("hold_rst_drop", 64'(ARVALID), 64'd0);
        ARESETn = 1'b1;
        M_ARVALID = 4'b1111;
        #1;
        chk("hold_rst_first", 64'(M_ARREADY), 64'h1);
        M_ARVALID = 4'b0000;
        RVALID = 1'b1; RMASTER = 4'b0100; RLAST = 1'b1; M_RREADY = 4'b0100;
        tick();
        chk("hold_outst_clr", 64'(ROUTE_ERR), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
